// File: rtl/uart_rx_fifo_if.sv
//------------------------------------------------------------------------------
// Module      : uart_rx_fifo_if
// Description : Core-side bus of the UART receiver: show-ahead FIFO read port
//               plus sticky error flags and their clear strobe.
//               Optional feature macro: UART_RX_PARITY_EN (adds parity_err).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
) ();
    logic                       rd_en;
    logic [7:0]                 rd_data;
    logic                       empty;
    logic                       full;
    logic [$clog2(DEPTH):0]     count;
    logic                       frame_err;
    logic                       overrun;
    logic                       clr_err;
`ifdef UART_RX_PARITY_EN
    logic                       parity_err;
`endif

    // Core side: pops entries and clears errors.
    modport master (
        output rd_en,
        output clr_err,
        input  rd_data,
        input  empty,
        input  full,
        input  count,
        input  frame_err,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  overrun
    );

    // Receiver side: supplies data and status.
    modport slave (
        input  rd_en,
        input  clr_err,
        output rd_data,
        output empty,
        output full,
        output count,
        output frame_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output overrun
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module      : uart_rx_fifo
// Description : UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined)
//               feeding a show-ahead FIFO with sticky frame/overrun errors.
//               Optional feature macro: UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_rx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  wire             clk,
    input  wire             areset,
    input  wire             rx_serial,
    uart_rx_fifo_if.slave   bus
);

    localparam int c_clks_per_bit = CLK_FREQ / BAUD;
    localparam int c_cnt_bits     = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
    localparam int c_ptr_bits     = $clog2(DEPTH);
    localparam int c_count_bits   = c_ptr_bits + 1;

    localparam logic [c_cnt_bits-1:0]   c_bit_last  = c_cnt_bits'(c_clks_per_bit - 1);
    localparam logic [c_cnt_bits-1:0]   c_half_last = c_cnt_bits'(c_clks_per_bit / 2 - 1);
    localparam logic [c_count_bits-1:0] c_depth_cnt = c_count_bits'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    logic                       r_sync1;
    logic                       r_sync2;
    logic                       w_rxs;

    logic [c_cnt_bits-1:0]      r_cnt;
    logic [2:0]                 r_idx;
    logic [7:0]                 r_shift;
    logic                       r_armed;

    logic                       w_cnt_clr;
    logic                       w_shift_en;
    logic                       w_push_req;
    logic                       w_frame_set;

    logic [7:0]                 r_mem [DEPTH];
    logic [c_ptr_bits-1:0]      r_wr_ptr;
    logic [c_ptr_bits-1:0]      r_rd_ptr;
    logic [c_count_bits-1:0]    r_count;
    logic                       r_frame_err;
    logic                       r_overrun;

    logic                       w_empty;
    logic                       w_full;
    logic                       w_do_push;
    logic                       w_do_pop;
    logic                       w_overrun_set;

`ifdef UART_RX_PARITY_EN
    logic                       r_par_bad;
    logic                       r_parity_err;
    logic                       w_par_set;
`endif

    assign w_rxs = r_sync2;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle strobes of the deframer.
    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_push_req  = 1'b0;
        w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_set   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_armed && !w_rxs) begin
                    w_next    = S_START;
                    w_cnt_clr = 1'b1;
                end
            end
            S_START: begin
                // Mid start bit: a high line here was only a glitch.
                if (r_cnt == c_half_last) begin
                    w_cnt_clr = 1'b1;
                    w_next    = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_next = S_PARITY;
`else
                        w_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                // Even parity: data XOR parity bit must be zero.
                if (r_cnt == c_bit_last) begin
                    w_cnt_clr = 1'b1;
                    w_par_set = (^r_shift) ^ w_rxs;
                    w_next    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_IDLE;
                    if (w_rxs) begin
`ifdef UART_RX_PARITY_EN
                        w_push_req = !r_par_bad;
`else
                        w_push_req = 1'b1;
`endif
                    end else begin
                        w_frame_set = 1'b1;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bit timing counter, bit index, shift register and start-bit arming.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_armed <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + c_cnt_bits'(1);
            end

            if (r_state == S_IDLE) begin
                r_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift[r_idx] <= w_rxs;
            end

            // A stop bit low may be a break; wait for the line to return high.
            if (w_frame_set) begin
                r_armed <= 1'b0;
            end else if (r_state == S_IDLE && w_rxs) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Per-frame parity verdict and the sticky parity error.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_par_bad <= 1'b0;
            end else if (w_par_set) begin
                r_par_bad <= 1'b1;
            end
            r_parity_err <= w_par_set | (r_parity_err & ~bus.clr_err);
        end
    end

    assign bus.parity_err = r_parity_err;
`endif

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_depth_cnt);
    assign w_do_pop      = bus.rd_en && !w_empty;
    // A full FIFO still accepts a byte when the core pops in the same cycle.
    assign w_do_push     = w_push_req && (!w_full || bus.rd_en);
    assign w_overrun_set = w_push_req && w_full && !bus.rd_en;

    // FIFO storage; contents are never observed past the count, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_bits'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_bits'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_count_bits'(1);
                2'b01:   r_count <= r_count - c_count_bits'(1);
                default: r_count <= r_count;
            endcase
            r_frame_err <= w_frame_set   | (r_frame_err & ~bus.clr_err);
            r_overrun   <= w_overrun_set | (r_overrun   & ~bus.clr_err);
        end
    end

    assign bus.rd_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo with a byte scoreboard.
//               Optional feature macro: UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 4;
    localparam int C        = 16;
`ifdef UART_RX_PARITY_EN
    localparam int c_push_dly = 2 + C / 2 + 10 * C;
`else
    localparam int c_push_dly = 2 + C / 2 + 9 * C;
`endif

    logic clk       = 1'b0;
    logic areset    = 1'b0;
    logic rx_serial = 1'b1;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .rx_serial (rx_serial),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialize one frame; line is left idle high afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        wait_clk(C);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_clk(C);
        end
`ifdef UART_RX_PARITY_EN
        rx_serial = ^b;
        wait_clk(C);
`endif
        rx_serial = stop_bit;
        wait_clk(C);
        rx_serial = 1'b1;
    endtask

    task automatic pulse_rd();
        bus.rd_en = 1'b1;
        wait_clk(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        wait_clk(1);
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b0;
        wait_clk(3);
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", bus.frame_err, bus.overrun); end
        areset = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_single();
        logic [7:0] exp;
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_clk(c_push_dly);
                n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_latency_early: empty got %b want 1", bus.empty); end
                wait_clk(1);
                n_cmp++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL single_latency: empty got %b want 0", bus.empty); end
                n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.count); end
                exp = sb.pop_front();
                n_cmp++; if (bus.rd_data !== exp) begin n_err++; $display("FAIL single_data: got %h want %h", bus.rd_data, exp); end
                pulse_rd();
                n_cmp++; if (bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin n_err++; $display("FAIL single_pop: empty %b rd_data %h want 1/00", bus.empty, bus.rd_data); end
            end
        join
        wait_clk(2);
    endtask

    task automatic test_glitch();
        rx_serial = 1'b0;
        wait_clk(6);
        rx_serial = 1'b1;
        wait_clk(3 * C);
        n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin n_err++; $display("FAIL glitch_push: empty %b count %0d want 1/0", bus.empty, bus.count); end
        n_cmp++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin n_err++; $display("FAIL glitch_flags: got %b%b want 00", bus.frame_err, bus.overrun); end
    endtask

    task automatic test_frame_err();
        logic [7:0] exp;
        send_frame(8'h3C, 1'b0);
        wait_clk(2);
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL ferr_nopush: empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", bus.frame_err); end
        pulse_clr();
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clear: got %b want 0", bus.frame_err); end
        wait_clk(4);
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_clk(2);
        exp = sb.pop_front();
        n_cmp++; if (bus.empty !== 1'b0 || bus.rd_data !== exp) begin n_err++; $display("FAIL ferr_recover: empty %b rd_data %h want 0/%h", bus.empty, bus.rd_data, exp); end
        pulse_rd();
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == 4) begin
                n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovr_full4: got %b want 1", bus.full); end
                n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
            end
        end
        wait_clk(2);
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL ovr_count: got %0d want 4", bus.count); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = sb.pop_front();
            n_cmp++; if (bus.rd_data !== exp) begin n_err++; $display("FAIL ovr_order[%0d]: got %h want %h", i, bus.rd_data, exp); end
            pulse_rd();
        end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL ovr_drain: empty got %b want 1", bus.empty); end
        pulse_clr();
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(fill[i]);
            send_frame(fill[i], 1'b1);
        end
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b want 1", bus.full); end
        sb.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1);
            begin
                wait_clk(c_push_dly);
                exp = sb.pop_front();
                n_cmp++; if (bus.rd_data !== exp) begin n_err++; $display("FAIL b2b_head: got %h want %h", bus.rd_data, exp); end
                pulse_rd();
                n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", bus.count); end
                n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
            end
        join
        wait_clk(2);
        for (int i = 0; i < DEPTH; i++) begin
            exp = sb.pop_front();
            n_cmp++; if (bus.rd_data !== exp) begin n_err++; $display("FAIL b2b_order[%0d]: got %h want %h", i, bus.rd_data, exp); end
            pulse_rd();
        end
        n_cmp++; if (bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin n_err++; $display("FAIL b2b_drain: empty %b rd_data %h want 1/00", bus.empty, bus.rd_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        logic [7:0] part = 8'hF0;
        send_frame(8'h77, 1'b1);
        wait_clk(2);
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL rst_pre_count: got %0d want 1", bus.count); end
        rx_serial = 1'b0;
        wait_clk(C);
        for (int i = 0; i < 4; i++) begin
            rx_serial = part[i];
            wait_clk(C);
        end
        areset = 1'b0;
        wait_clk(2);
        n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.full !== 1'b0) begin n_err++; $display("FAIL rst_mid_fifo: empty %b count %0d full %b want 1/0/0", bus.empty, bus.count, bus.full); end
        n_cmp++; if (bus.rd_data !== 8'h00 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_out: rd_data %h flags %b%b want 00/00", bus.rd_data, bus.frame_err, bus.overrun); end
        rx_serial = 1'b1;
        wait_clk(2);
        areset = 1'b1;
        wait_clk(4);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_clk(2);
        exp = sb.pop_front();
        n_cmp++; if (bus.count !== 3'd1 || bus.rd_data !== exp) begin n_err++; $display("FAIL rst_recover: count %0d rd_data %h want 1/%h", bus.count, bus.rd_data, exp); end
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_recover_ferr: got %b want 0", bus.frame_err); end
        pulse_rd();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b = 8'h07;
        rx_serial = 1'b0;
        wait_clk(C);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_clk(C);
        end
        rx_serial = 1'b0;
        wait_clk(C);
        rx_serial = 1'b1;
        wait_clk(C + 2);
        n_cmp++; if (bus.parity_err !== 1'b1) begin n_err++; $display("FAIL par_set: got %b want 1", bus.parity_err); end
        n_cmp++; if (bus.empty !== 1'b1 || bus.frame_err !== 1'b0) begin n_err++; $display("FAIL par_nopush: empty %b frame_err %b want 1/0", bus.empty, bus.frame_err); end
        pulse_clr();
        n_cmp++; if (bus.parity_err !== 1'b0) begin n_err++; $display("FAIL par_clear: got %b want 0", bus.parity_err); end
    endtask
`endif

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
